// File: rtl/bsg_axi_bus_pkg.sv
// Shared types and AXI encodings for the write arbiter slice.
package bsg_axi_bus_pkg;

   typedef enum logic [1:0] {
      e_wr_arb_idle = 2'd0,
      e_wr_arb_addr = 2'd1,
      e_wr_arb_data = 2'd2
   } wr_arb_state_e;

   localparam logic [1:0] axi_burst_fixed_gp = 2'b00;
   localparam logic [1:0] axi_burst_incr_gp  = 2'b01;
   localparam logic [1:0] axi_burst_wrap_gp  = 2'b10;

   localparam logic [1:0] axi_resp_okay_gp   = 2'b00;
   localparam logic [1:0] axi_resp_exokay_gp = 2'b01;
   localparam logic [1:0] axi_resp_slverr_gp = 2'b10;
   localparam logic [1:0] axi_resp_decerr_gp = 2'b11;

   // clog2 that never returns 0, so single-entry selectors still get one bit
   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin grant among request bits; priority moves past the winner on yumi.
module bsg_arb_round_robin
   import bsg_axi_bus_pkg::*;
#(
   parameter  int unsigned width_p      = 2,
   localparam int unsigned sel_width_lp = safe_clog2(width_p)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [width_p-1:0]      reqs_i,
   input  logic                    yumi_i,
   output logic [width_p-1:0]      grants_o,
   output logic [sel_width_lp-1:0] sel_o,
   output logic                    v_o
);

   logic [sel_width_lp-1:0] ptr;

   // first requester at or after ptr, wrapping
   always_comb begin
      int idx;
      grants_o = '0;
      sel_o    = '0;
      v_o      = 1'b0;
      idx      = 0;
      for (int k = 0; k < int'(width_p); k++) begin
         idx = (int'(ptr) + k) % int'(width_p);
         if (!v_o && reqs_i[idx]) begin
            v_o           = 1'b1;
            sel_o         = sel_width_lp'(idx);
            grants_o[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         ptr <= '0;
      else if (yumi_i)
         ptr <= (32'(sel_o) == width_p - 1) ? '0 : sel_o + 1'b1;
   end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// Serialises AW+W bursts from several slots onto one AXI4 write port,
// tagging IDs with the slot index and routing B back by that tag.
module axi4_wr_arbiter
   import bsg_axi_bus_pkg::*;
#(
   parameter  int unsigned slot_num_p        = 2,
   parameter  int unsigned id_width_p        = 6,
   parameter  int unsigned addr_width_p      = 64,
   parameter  int unsigned data_width_p      = 512,
   parameter  int unsigned max_outstanding_p = 4,
   localparam int unsigned strb_width_lp     = data_width_p / 8,
   localparam int unsigned sel_width_lp      = safe_clog2(slot_num_p),
   localparam int unsigned m_id_width_lp     = id_width_p + sel_width_lp,
   localparam int unsigned cnt_width_lp      = safe_clog2(max_outstanding_p + 1)
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,

   input  logic [slot_num_p*id_width_p-1:0]      s_awid_i,
   input  logic [slot_num_p*addr_width_p-1:0]    s_awaddr_i,
   input  logic [slot_num_p*8-1:0]               s_awlen_i,
   input  logic [slot_num_p*3-1:0]               s_awsize_i,
   input  logic [slot_num_p*2-1:0]               s_awburst_i,
   input  logic [slot_num_p-1:0]                 s_awvalid_i,
   output logic [slot_num_p-1:0]                 s_awready_o,

   input  logic [slot_num_p*data_width_p-1:0]    s_wdata_i,
   input  logic [slot_num_p*strb_width_lp-1:0]   s_wstrb_i,
   input  logic [slot_num_p-1:0]                 s_wlast_i,
   input  logic [slot_num_p-1:0]                 s_wvalid_i,
   output logic [slot_num_p-1:0]                 s_wready_o,

   output logic [slot_num_p*id_width_p-1:0]      s_bid_o,
   output logic [slot_num_p*2-1:0]               s_bresp_o,
   output logic [slot_num_p-1:0]                 s_bvalid_o,
   input  logic [slot_num_p-1:0]                 s_bready_i,

   output logic [m_id_width_lp-1:0]              m_awid_o,
   output logic [addr_width_p-1:0]               m_awaddr_o,
   output logic [7:0]                            m_awlen_o,
   output logic [2:0]                            m_awsize_o,
   output logic [1:0]                            m_awburst_o,
   output logic                                  m_awvalid_o,
   input  logic                                  m_awready_i,

   output logic [data_width_p-1:0]               m_wdata_o,
   output logic [strb_width_lp-1:0]              m_wstrb_o,
   output logic                                  m_wlast_o,
   output logic                                  m_wvalid_o,
   input  logic                                  m_wready_i,

   input  logic [m_id_width_lp-1:0]              m_bid_i,
   input  logic [1:0]                            m_bresp_i,
   input  logic                                  m_bvalid_i,
   output logic                                  m_bready_o,

   output logic                                  error_o
);

   wr_arb_state_e state, state_n;

   logic [cnt_width_lp-1:0] cnt   [slot_num_p];
   logic [cnt_width_lp-1:0] cnt_n [slot_num_p];

   logic [slot_num_p-1:0]   eligible, grants, b_match, inc, dec;
   logic [sel_width_lp-1:0] grant_sel, slot_sel, b_sel;
   logic                    grant_v, aw_hs, w_done, b_bad, b_hs, underflow, error_n;

   always_comb begin
      for (int i = 0; i < int'(slot_num_p); i++)
         eligible[i] = s_awvalid_i[i] & (cnt[i] < cnt_width_lp'(max_outstanding_p));
   end

   bsg_arb_round_robin #(.width_p(slot_num_p)) rr (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .reqs_i   (eligible),
      .yumi_i   (aw_hs),
      .grants_o (grants),
      .sel_o    (grant_sel),
      .v_o      (grant_v)
   );

   assign aw_hs       = (state == e_wr_arb_idle) & grant_v & ~reset_i;
   assign m_awvalid_o = (state == e_wr_arb_addr);

   // W passes straight through from the latched slot while in DATA
   assign m_wdata_o  = s_wdata_i[slot_sel*data_width_p +: data_width_p];
   assign m_wstrb_o  = s_wstrb_i[slot_sel*strb_width_lp +: strb_width_lp];
   assign m_wlast_o  = s_wlast_i[slot_sel];
   assign m_wvalid_o = (state == e_wr_arb_data) & s_wvalid_i[slot_sel];
   assign w_done     = m_wvalid_o & m_wready_i & m_wlast_o;

   always_comb begin
      state_n     = state;
      s_awready_o = '0;
      s_wready_o  = '0;
      case (state)
         e_wr_arb_idle: begin
            if (aw_hs) begin
               s_awready_o = grants;
               state_n     = e_wr_arb_addr;
            end
         end
         e_wr_arb_addr: begin
            if (m_awready_i)
               state_n = e_wr_arb_data;
         end
         e_wr_arb_data: begin
            for (int i = 0; i < int'(slot_num_p); i++)
               s_wready_o[i] = (slot_sel == sel_width_lp'(i)) & m_wready_i;
            if (w_done)
               state_n = e_wr_arb_idle;
         end
         default: state_n = e_wr_arb_idle;
      endcase
   end

   // B routing by the slot tag in the upper ID bits; unknown tags are sunk
   assign b_sel = m_bid_i[m_id_width_lp-1 -: sel_width_lp];
   assign b_bad = (32'(b_sel) >= slot_num_p);

   always_comb begin
      m_bready_o = b_bad;
      s_bvalid_o = '0;
      b_match    = '0;
      for (int i = 0; i < int'(slot_num_p); i++) begin
         if (b_sel == sel_width_lp'(i)) begin
            b_match[i]    = 1'b1;
            s_bvalid_o[i] = m_bvalid_i;
            m_bready_o    = s_bready_i[i];
         end
      end
   end

   assign s_bid_o   = {slot_num_p{m_bid_i[id_width_p-1:0]}};
   assign s_bresp_o = {slot_num_p{m_bresp_i}};
   assign b_hs      = m_bvalid_i & m_bready_o;

   always_comb begin
      underflow = 1'b0;
      inc       = '0;
      dec       = '0;
      for (int i = 0; i < int'(slot_num_p); i++) begin
         inc[i]   = aw_hs & (grant_sel == sel_width_lp'(i));
         dec[i]   = b_hs & b_match[i];
         cnt_n[i] = cnt[i];
         if (inc[i] && !dec[i])
            cnt_n[i] = cnt[i] + 1'b1;
         else if (dec[i] && !inc[i]) begin
            if (cnt[i] == '0)
               underflow = 1'b1;
            else
               cnt_n[i] = cnt[i] - 1'b1;
         end
      end
   end

   assign error_n = error_o | (b_hs & b_bad) | underflow;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state    <= e_wr_arb_idle;
         error_o  <= 1'b0;
         slot_sel <= '0;
         for (int i = 0; i < int'(slot_num_p); i++)
            cnt[i] <= '0;
      end else begin
         state   <= state_n;
         error_o <= error_n;
         for (int i = 0; i < int'(slot_num_p); i++)
            cnt[i] <= cnt_n[i];
         if (aw_hs)
            slot_sel <= grant_sel;
      end
   end

   // AW payload is captured on the slot handshake and held through ADDR
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         m_awid_o    <= '0;
         m_awaddr_o  <= '0;
         m_awlen_o   <= '0;
         m_awsize_o  <= '0;
         m_awburst_o <= '0;
      end else if (aw_hs) begin
         m_awid_o    <= {grant_sel, s_awid_i[grant_sel*id_width_p +: id_width_p]};
         m_awaddr_o  <= s_awaddr_i[grant_sel*addr_width_p +: addr_width_p];
         m_awlen_o   <= s_awlen_i[grant_sel*8 +: 8];
         m_awsize_o  <= s_awsize_i[grant_sel*3 +: 3];
         m_awburst_o <= s_awburst_i[grant_sel*2 +: 2];
      end
   end

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Directed bench for axi4_wr_arbiter with three slots and narrow buses.
module tb_axi4_wr_arbiter;
   import bsg_axi_bus_pkg::*;

   localparam int unsigned N    = 3;
   localparam int unsigned IW   = 6;
   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned SW   = DW / 8;
   localparam int unsigned MO   = 4;
   localparam int unsigned SELW = 2;
   localparam int unsigned MIW  = IW + SELW;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic [N*IW-1:0]   s_awid_i;
   logic [N*AW-1:0]   s_awaddr_i;
   logic [N*8-1:0]    s_awlen_i;
   logic [N*3-1:0]    s_awsize_i;
   logic [N*2-1:0]    s_awburst_i;
   logic [N-1:0]      s_awvalid_i;
   logic [N-1:0]      s_awready_o;
   logic [N*DW-1:0]   s_wdata_i;
   logic [N*SW-1:0]   s_wstrb_i;
   logic [N-1:0]      s_wlast_i;
   logic [N-1:0]      s_wvalid_i;
   logic [N-1:0]      s_wready_o;
   logic [N*IW-1:0]   s_bid_o;
   logic [N*2-1:0]    s_bresp_o;
   logic [N-1:0]      s_bvalid_o;
   logic [N-1:0]      s_bready_i;
   logic [MIW-1:0]    m_awid_o;
   logic [AW-1:0]     m_awaddr_o;
   logic [7:0]        m_awlen_o;
   logic [2:0]        m_awsize_o;
   logic [1:0]        m_awburst_o;
   logic              m_awvalid_o;
   logic              m_awready_i;
   logic [DW-1:0]     m_wdata_o;
   logic [SW-1:0]     m_wstrb_o;
   logic              m_wlast_o;
   logic              m_wvalid_o;
   logic              m_wready_i;
   logic [MIW-1:0]    m_bid_i;
   logic [1:0]        m_bresp_i;
   logic              m_bvalid_i;
   logic              m_bready_o;
   logic              error_o;

   int total = 0;
   int bad   = 0;

   axi4_wr_arbiter #(
      .slot_num_p        (N),
      .id_width_p        (IW),
      .addr_width_p      (AW),
      .data_width_p      (DW),
      .max_outstanding_p (MO)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .s_awid_i    (s_awid_i),
      .s_awaddr_i  (s_awaddr_i),
      .s_awlen_i   (s_awlen_i),
      .s_awsize_i  (s_awsize_i),
      .s_awburst_i (s_awburst_i),
      .s_awvalid_i (s_awvalid_i),
      .s_awready_o (s_awready_o),
      .s_wdata_i   (s_wdata_i),
      .s_wstrb_i   (s_wstrb_i),
      .s_wlast_i   (s_wlast_i),
      .s_wvalid_i  (s_wvalid_i),
      .s_wready_o  (s_wready_o),
      .s_bid_o     (s_bid_o),
      .s_bresp_o   (s_bresp_o),
      .s_bvalid_o  (s_bvalid_o),
      .s_bready_i  (s_bready_i),
      .m_awid_o    (m_awid_o),
      .m_awaddr_o  (m_awaddr_o),
      .m_awlen_o   (m_awlen_o),
      .m_awsize_o  (m_awsize_o),
      .m_awburst_o (m_awburst_o),
      .m_awvalid_o (m_awvalid_o),
      .m_awready_i (m_awready_i),
      .m_wdata_o   (m_wdata_o),
      .m_wstrb_o   (m_wstrb_o),
      .m_wlast_o   (m_wlast_o),
      .m_wvalid_o  (m_wvalid_o),
      .m_wready_i  (m_wready_i),
      .m_bid_i     (m_bid_i),
      .m_bresp_i   (m_bresp_i),
      .m_bvalid_i  (m_bvalid_i),
      .m_bready_o  (m_bready_o),
      .error_o     (error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge; checks follow 1 unit later
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      s_awid_i    = '0;
      s_awaddr_i  = '0;
      s_awlen_i   = '0;
      s_awsize_i  = '0;
      s_awburst_i = '0;
      s_awvalid_i = '0;
      s_wdata_i   = '0;
      s_wstrb_i   = '1;
      s_wlast_i   = '0;
      s_wvalid_i  = '0;
      s_bready_i  = '0;
      m_awready_i = 1'b1;
      m_wready_i  = 1'b1;
      m_bid_i     = '0;
      m_bresp_i   = '0;
      m_bvalid_i  = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_i = 1'b1;
      step();
      step();
      reset_i = 1'b0;
   endtask

   function automatic logic [N-1:0] onehot(input int s);
      logic [N-1:0] v;
      v    = '0;
      v[s] = 1'b1;
      return v;
   endfunction

   // one full burst from a single slot with both master readies high
   task automatic run_burst(input int slot, input logic [IW-1:0] id, input int len,
                            input logic [AW-1:0] addr);
      logic [N-1:0] oh;
      oh = onehot(slot);
      s_awvalid_i                   = oh;
      s_awid_i[slot*IW +: IW]       = id;
      s_awlen_i[slot*8 +: 8]        = 8'(len);
      s_awaddr_i[slot*AW +: AW]     = addr;
      s_awsize_i[slot*3 +: 3]       = 3'd2;
      s_awburst_i[slot*2 +: 2]      = axi_burst_incr_gp;
      #1;
      check("awready", 64'(s_awready_o), 64'(oh));
      step();
      s_awvalid_i = '0;
      #1;
      check("m_awvalid", 64'(m_awvalid_o), 64'(1'b1));
      check("m_awid", 64'(m_awid_o), 64'({2'(slot), id}));
      check("m_awaddr", 64'(m_awaddr_o), 64'(addr));
      check("m_awlen", 64'(m_awlen_o), 64'(len));
      step();
      for (int k = 0; k <= len; k++) begin
         s_wvalid_i                 = oh;
         s_wdata_i[slot*DW +: DW]   = 32'hD000_0000 | (32'(slot) << 8) | 32'(k);
         s_wlast_i                  = (k == len) ? oh : '0;
         #1;
         check("m_wvalid", 64'(m_wvalid_o), 64'(1'b1));
         check("m_wdata", 64'(m_wdata_o), 64'(32'hD000_0000 | (32'(slot) << 8) | 32'(k)));
         check("m_wlast", 64'(m_wlast_o), 64'(k == len));
         check("s_wready", 64'(s_wready_o), 64'(oh));
         step();
      end
      s_wvalid_i = '0;
      s_wlast_i  = '0;
      #1;
      check("w_idle", 64'(m_wvalid_o), 64'(1'b0));
      check("state_idle", 64'(dut.state), 64'(e_wr_arb_idle));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      do_reset();

      // reset state
      #1;
      check("rst_awready", 64'(s_awready_o), 64'(0));
      check("rst_awvalid", 64'(m_awvalid_o), 64'(0));
      check("rst_wvalid", 64'(m_wvalid_o), 64'(0));
      check("rst_bready", 64'(m_bready_o), 64'(0));
      check("rst_bvalid", 64'(s_bvalid_o), 64'(0));
      check("rst_error", 64'(error_o), 64'(0));
      check("rst_state", 64'(dut.state), 64'(e_wr_arb_idle));
      check("rst_cnt1", 64'(dut.cnt[1]), 64'(0));

      // single 4-beat burst from slot 1
      run_burst(1, 6'h2A, 3, 32'h0000_1000);
      check("s1_cnt1", 64'(dut.cnt[1]), 64'(1));

      // slots 0 and 1 compete with single-beat bursts
      do_reset();
      s_awvalid_i                = 3'b011;
      s_awid_i[0 +: IW]          = 6'h05;
      s_awid_i[IW +: IW]         = 6'h06;
      s_wvalid_i                 = 3'b011;
      s_wlast_i                  = 3'b011;
      s_wdata_i[0 +: DW]         = 32'hAAAA_0000;
      s_wdata_i[DW +: DW]        = 32'hBBBB_1111;
      for (int b = 0; b < 4; b++) begin
         #1;
         check("rr_awready", 64'(s_awready_o), 64'(onehot(b % 2)));
         step();
         check("rr_awid_tag", 64'(m_awid_o[MIW-1 -: SELW]), 64'(b % 2));
         step();
         check("rr_wdata", 64'(m_wdata_o), 64'((b % 2) ? 32'hBBBB_1111 : 32'hAAAA_0000));
         check("rr_wready", 64'(s_wready_o), 64'(onehot(b % 2)));
         step();
      end
      clear_inputs();

      // outstanding limit on slot 0
      do_reset();
      s_awvalid_i = 3'b001;
      s_wvalid_i  = 3'b001;
      s_wlast_i   = 3'b001;
      for (int b = 0; b < 4; b++) begin
         #1;
         check("lim_awready", 64'(s_awready_o), 64'(3'b001));
         step();
         step();
         step();
      end
      #1;
      check("lim_stall", 64'(s_awready_o), 64'(0));
      check("lim_cnt0", 64'(dut.cnt[0]), 64'(4));
      s_awvalid_i         = 3'b011;
      s_wvalid_i          = 3'b011;
      s_wlast_i           = 3'b011;
      s_wdata_i[DW +: DW] = 32'h1111_2222;
      #1;
      check("lim_slot1_grant", 64'(s_awready_o), 64'(3'b010));
      step();
      check("lim_slot1_tag", 64'(m_awid_o[MIW-1 -: SELW]), 64'(1));
      step();
      check("lim_slot1_wdata", 64'(m_wdata_o), 64'(32'h1111_2222));
      step();
      s_awvalid_i = 3'b001;
      #1;
      check("lim_still_stall", 64'(s_awready_o), 64'(0));
      m_bvalid_i = 1'b1;
      m_bid_i    = {2'd0, 6'h11};
      m_bresp_i  = axi_resp_okay_gp;
      s_bready_i = 3'b001;
      #1;
      check("b0_bvalid", 64'(s_bvalid_o), 64'(3'b001));
      check("b0_bready", 64'(m_bready_o), 64'(1));
      check("b0_bid", 64'(s_bid_o[0 +: IW]), 64'(6'h11));
      step();
      m_bvalid_i = 1'b0;
      #1;
      check("b0_cnt0", 64'(dut.cnt[0]), 64'(3));
      check("b0_release", 64'(s_awready_o), 64'(3'b001));

      // B for slot 1 in the same cycle slot 1's AW is accepted
      s_awvalid_i = 3'b010;
      m_bvalid_i  = 1'b1;
      m_bid_i     = {2'd1, 6'h06};
      s_bready_i  = 3'b010;
      #1;
      check("sim_awready", 64'(s_awready_o), 64'(3'b010));
      check("sim_bready", 64'(m_bready_o), 64'(1));
      check("sim_bvalid", 64'(s_bvalid_o), 64'(3'b010));
      step();
      m_bvalid_i  = 1'b0;
      s_awvalid_i = '0;
      #1;
      check("sim_cnt1", 64'(dut.cnt[1]), 64'(1));
      check("sim_cnt0", 64'(dut.cnt[0]), 64'(3));
      step();
      step();
      s_wvalid_i = '0;
      s_wlast_i  = '0;
      #1;
      check("sim_idle", 64'(dut.state), 64'(e_wr_arb_idle));

      // B backpressure, then a tag with no slot behind it
      m_bvalid_i = 1'b1;
      m_bid_i    = {2'd0, 6'h22};
      s_bready_i = '0;
      #1;
      check("bp_bready", 64'(m_bready_o), 64'(0));
      check("bp_bvalid", 64'(s_bvalid_o), 64'(3'b001));
      step();
      check("bp_cnt0", 64'(dut.cnt[0]), 64'(3));
      m_bid_i = {2'd3, 6'h01};
      #1;
      check("bad_bready", 64'(m_bready_o), 64'(1));
      check("bad_bvalid", 64'(s_bvalid_o), 64'(0));
      check("bad_err_pre", 64'(error_o), 64'(0));
      step();
      m_bvalid_i = 1'b0;
      m_bid_i    = '0;
      #1;
      check("bad_err", 64'(error_o), 64'(1));
      check("bad_cnt0", 64'(dut.cnt[0]), 64'(3));
      step();
      check("bad_err_sticky", 64'(error_o), 64'(1));

      // B for a slot with nothing outstanding
      do_reset();
      #1;
      check("uf_err_rst", 64'(error_o), 64'(0));
      m_bvalid_i = 1'b1;
      m_bid_i    = {2'd2, 6'h03};
      s_bready_i = 3'b100;
      step();
      m_bvalid_i = 1'b0;
      m_bid_i    = '0;
      s_bready_i = '0;
      #1;
      check("uf_err", 64'(error_o), 64'(1));
      check("uf_cnt2", 64'(dut.cnt[2]), 64'(0));

      // reset in the middle of a DATA burst
      do_reset();
      s_awvalid_i         = 3'b010;
      s_awid_i[IW +: IW]  = 6'h09;
      s_awlen_i[8 +: 8]   = 8'd3;
      step();
      s_awvalid_i = '0;
      step();
      s_wvalid_i = 3'b010;
      #1;
      check("mid_wvalid", 64'(m_wvalid_o), 64'(1));
      check("mid_cnt1", 64'(dut.cnt[1]), 64'(1));
      step();
      reset_i = 1'b1;
      step();
      #1;
      check("mid_rst_wvalid", 64'(m_wvalid_o), 64'(0));
      check("mid_rst_wready", 64'(s_wready_o), 64'(0));
      check("mid_rst_awvalid", 64'(m_awvalid_o), 64'(0));
      check("mid_rst_awready", 64'(s_awready_o), 64'(0));
      check("mid_rst_bready", 64'(m_bready_o), 64'(0));
      check("mid_rst_state", 64'(dut.state), 64'(e_wr_arb_idle));
      check("mid_rst_cnt1", 64'(dut.cnt[1]), 64'(0));
      reset_i    = 1'b0;
      s_wvalid_i = '0;
      step();
      run_burst(1, 6'h15, 1, 32'h0000_2000);
      check("post_cnt1", 64'(dut.cnt[1]), 64'(1));
      check("post_err", 64'(error_o), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi4_wr_arbiter.md
Name: axi4_wr_arbiter

Overview:
- Shares one AXI4 write channel set (AW/W/B) between slot_num_p requesters.
- Sits between the per-slot write masters and the single downstream master write port. It replaces crossbar arbitration where a deterministic, bounded-outstanding write scheduler is required.
- Serialises AW and the matching W burst, tags outgoing IDs with the slot index, and routes B responses back by that tag.
- Enforces a per-slot outstanding-write limit.

Parameters:
- slot_num_p, 2: number of requesting slots (>=2).
- id_width_p, 6: per-slot AXI ID width.
- addr_width_p, 64: address width.
- data_width_p, 512: data width; strobe width is data_width_p/8.
- max_outstanding_p, 4: maximum un-responded writes per slot (>=1).
- Derived: sel_width_lp = `BSG_SAFE_CLOG2(slot_num_p); m_id_width_lp = id_width_p + sel_width_lp; cnt_width_lp = `BSG_SAFE_CLOG2(max_outstanding_p+1).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- s_awid_i  in  slot_num_p*id_width_p  per-slot AW ID
- s_awaddr_i  in  slot_num_p*addr_width_p  per-slot AW address
- s_awlen_i  in  slot_num_p*8  per-slot burst length
- s_awsize_i  in  slot_num_p*3  per-slot burst size
- s_awburst_i  in  slot_num_p*2  per-slot burst type
- s_awvalid_i  in  slot_num_p  per-slot AW valid
- s_awready_o  out  slot_num_p  per-slot AW ready
- s_wdata_i  in  slot_num_p*data_width_p  per-slot write data
- s_wstrb_i  in  slot_num_p*(data_width_p/8)  per-slot write strobe
- s_wlast_i  in  slot_num_p  per-slot last beat
- s_wvalid_i  in  slot_num_p  per-slot W valid
- s_wready_o  out  slot_num_p  per-slot W ready
- s_bid_o  out  slot_num_p*id_width_p  per-slot B ID
- s_bresp_o  out  slot_num_p*2  per-slot B response
- s_bvalid_o  out  slot_num_p  per-slot B valid
- s_bready_i  in  slot_num_p  per-slot B ready
- m_awid_o  out  m_id_width_lp  {slot index, slot awid}
- m_awaddr_o / m_awlen_o / m_awsize_o / m_awburst_o  out  addr_width_p/8/3/2  registered AW fields
- m_awvalid_o  out  1 ; m_awready_i  in  1
- m_wdata_o / m_wstrb_o / m_wlast_o / m_wvalid_o  out  data_width_p/(data_width_p/8)/1/1
- m_wready_i  in  1
- m_bid_i  in  m_id_width_lp ; m_bresp_i  in  2 ; m_bvalid_i  in  1 ; m_bready_o  out  1
- error_o  out  1  sticky protocol-error flag

Behaviour:
- Reset:
  - State goes to IDLE.
  - Round-robin pointer, all outstanding counters and error_o are cleared to 0.
  - All valid/ready outputs are 0.
  - Reset asserted mid-burst aborts immediately with no drain; both sides must be reset together.
- FSM states are IDLE, ADDR, DATA.
- IDLE:
  - Eligible[i] = s_awvalid_i[i] & (cnt[i] < max_outstanding_p).
  - The round-robin arbiter picks grant g among the eligible slots. s_awready_o[g] = 1 in the same cycle (combinational from eligible).
  - On that handshake: capture the AW fields into registers with m_awid = {g, s_awid[g]}, increment cnt[g], latch g, and go to ADDR.
  - With no eligible slot, stay in IDLE.
- ADDR:
  - m_awvalid_o = 1 from the registers. Slot-to-master AW latency is exactly 1 cycle.
  - On m_awready_i, go to DATA.
  - Register contents are stable while m_awvalid_o is high.
- DATA:
  - W channel of slot g is passed combinationally: m_w* = s_w*[g], s_wready_o[g] = m_wready_i. Other slots see wready 0.
  - On a handshake with wlast, go to IDLE and advance the RR pointer to g+1 (mod slot_num_p).
  - Beat count is not checked against awlen.
- W data is never forwarded before its AW is accepted downstream. A new AW is accepted only in IDLE, so throughput is at most one burst per (2 + beats) cycles.
- B path (independent of the FSM):
  - sel = m_bid_i[m_id_width_lp-1 -: sel_width_lp].
  - If sel < slot_num_p: s_bvalid_o[sel] = m_bvalid_i, m_bready_o = s_bready_i[sel], s_bid_o[sel] = low id_width_p bits, s_bresp_o[sel] = m_bresp_i.
  - If sel >= slot_num_p: m_bready_o = 1, the response is dropped, and error_o is set.
  - On a B handshake, decrement cnt[sel]. If it is already 0, hold it at 0 and set error_o.
- Simultaneous increment and decrement of the same slot leaves the counter unchanged.
- A counter at max blocks only its own slot.
- error_o is cleared only by reset.

Decomposition:
- Shared package (bsg_axi_bus_pkg) holds:
  - the FSM state enum (e_wr_arb_idle / e_wr_arb_addr / e_wr_arb_data);
  - the AXI burst/resp encoding constants.
- One sub-module: bsg_arb_round_robin (width slot_num_p, with yumi from the AW handshake) for the grant.
- Counters and the FSM stay inline.

Test Plan:
- Single slot 1 writes awlen=3 (4 beats), m_awready/m_wready held high:
  - s_awready[1] asserts in cycle 0; m_awvalid asserts in cycle 1 with m_awid={1,id}.
  - 4 W beats pass in cycles 2-5 with m_wlast on beat 4.
  - cnt[1] goes 0->1.
- Slots 0 and 1 continuously valid with awlen=0:
  - grants alternate 0,1,0,1 over 4 bursts.
  - no W beat from the non-granted slot appears on the master.
- Slot 0 issues 4 writes with no B returned (max_outstanding_p=4):
  - the 5th AW from slot 0 is stalled.
  - slot 1 is still granted.
  - returning one B with bid={0,x} releases slot 0 on the next IDLE.
- B for slot 1 arrives while slot 1's AW is accepted in the same cycle: cnt[1] is unchanged.
- B backpressure and bad tag:
  - with s_bready[0]=0, m_bready_o=0 and bvalid is held.
  - with slot_num_p=3 and bid prefix 3, the response is consumed and error_o=1.
- reset_i asserted in DATA mid-burst:
  - next cycle all valids/readies are 0, state is IDLE, counters are 0.
  - a fresh burst then completes normally.
